// File: rtl/mem_probe_pkg.sv
// rtl/mem_probe_pkg.sv - shared types and widths for the memory probe controller
package mem_probe_pkg;

    localparam int IO_W   = 8;
    localparam int PCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } probe_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus counter debounce with rising-edge event
module key_debounce #(
    parameter int DEB_CYC = 500000,
    parameter int CNT_W   = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
                // Level only moves after DEB_CYC consecutive mismatching cycles.
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_probe_ctrl.sv
// rtl/mem_probe_ctrl.sv - drives io/sw_src probe requests into the core, manual or auto-scan
module mem_probe_ctrl
    import mem_probe_pkg::*;
#(
    parameter int DEB_CYC   = 500000,
    parameter int SCAN_DIV  = 25000000,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IO_W-1:0]   sw_addr,
    input  logic              key_step,
    input  logic              key_auto,
    input  logic              mem_we,
    output logic [IO_W-1:0]   io,
    output logic              sw_src,
    output logic              auto_mode,
    output logic              probe_done,
    output logic [PCNT_W-1:0] probe_cnt
);

    probe_state_t     state;
    probe_state_t     next_state;
    logic [IO_W-1:0]  addr_s1;
    logic [IO_W-1:0]  addr_s2;
    logic [IO_W-1:0]  scan_addr;
    logic [CNT_W-1:0] scan_cnt;
    logic             step_rise;
    logic             auto_rise;
    logic             step_lvl_unused;
    logic             auto_lvl_unused;
    logic             scan_hit;
    logic             trigger;

    key_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_step_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_step),
        .level (step_lvl_unused),
        .rise  (step_rise)
    );

    key_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_auto_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_auto),
        .level (auto_lvl_unused),
        .rise  (auto_rise)
    );

    assign scan_hit = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign trigger  = auto_mode ? scan_hit : step_rise;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Triggers outside IDLE are simply not looked at, so they are dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = ARM;
            ARM:     if (!mem_we) next_state = CAPTURE;
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            addr_s1    <= '0;
            addr_s2    <= '0;
            io         <= '0;
            sw_src     <= 1'b0;
            probe_done <= 1'b0;
            probe_cnt  <= '0;
        end else begin
            addr_s1    <= sw_addr;
            addr_s2    <= addr_s1;
            sw_src     <= (next_state == CAPTURE);
            probe_done <= (next_state == DONE);
            probe_cnt  <= probe_cnt + PCNT_W'(next_state == DONE);
            if (state == IDLE && trigger) begin
                io <= auto_mode ? scan_addr : addr_s2;
            end
        end
    end

    // Scan counter only runs in auto mode; entry restarts the walk from 0.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            auto_mode <= 1'b0;
            scan_cnt  <= '0;
            scan_addr <= '0;
        end else begin
            if (auto_rise) begin
                auto_mode <= ~auto_mode;
                scan_cnt  <= '0;
            end else if (auto_mode) begin
                scan_cnt <= scan_hit ? '0 : scan_cnt + 1'b1;
            end

            if (auto_rise && !auto_mode) begin
                scan_addr <= '0;
            end else if (state == DONE && auto_mode) begin
                scan_addr <= scan_addr + IO_W'(ADDR_STEP);
            end
        end
    end

endmodule

// File: tb/tb_mem_probe_ctrl.sv
// tb/tb_mem_probe_ctrl.sv - directed self-checking bench for mem_probe_ctrl
module tb_mem_probe_ctrl;
    import mem_probe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sw_addr;
    logic        key_step;
    logic        key_auto;
    logic        mem_we;
    logic [7:0]  io;
    logic        sw_src;
    logic        auto_mode;
    logic        probe_done;
    logic [15:0] probe_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int dbl      = 0;
    logic       prev_src = 1'b0;
    logic [7:0] last_io  = 8'h00;

    mem_probe_ctrl #(
        .DEB_CYC   (4),
        .SCAN_DIV  (20),
        .ADDR_STEP (4),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_addr    (sw_addr),
        .key_step   (key_step),
        .key_auto   (key_auto),
        .mem_we     (mem_we),
        .io         (io),
        .sw_src     (sw_src),
        .auto_mode  (auto_mode),
        .probe_done (probe_done),
        .probe_cnt  (probe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sw_src) begin
            pulses++;
            last_io = io;
            if (prev_src) dbl++;
        end
        prev_src = sw_src;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_src(input int max, output int n);
        n = 0;
        while (sw_src !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("sw_src_timeout", {31'd0, sw_src}, 32'd1);
    endtask

    task automatic wait_arm(input int max);
        int n;
        n = 0;
        while (dut.state !== ARM && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("arm_timeout", {30'd0, dut.state}, {30'd0, ARM});
    endtask

    initial begin
        int n;
        int bad;
        int base;

        rst_n = 1'b1; key_step = 1'b1; key_auto = 1'b1; sw_addr = 8'h00; mem_we = 1'b0;
        tick(3);
        chk("rst_io", {24'd0, io}, 32'h0);
        chk("rst_sw_src", {31'd0, sw_src}, 32'h0);
        chk("rst_auto", {31'd0, auto_mode}, 32'h0);
        chk("rst_done", {31'd0, probe_done}, 32'h0);
        chk("rst_cnt", {16'd0, probe_cnt}, 32'h0);

        rst_n = 1'b0; key_step = 1'b0; key_auto = 1'b0;
        tick(25);
        chk("idle_pulses", pulses, 0);
        chk("idle_cnt", {16'd0, probe_cnt}, 32'h0);

        // Manual probe
        sw_addr = 8'h1C; key_step = 1'b1;
        wait_src(20, n);
        chk("man_io", {24'd0, io}, 32'h1C);
        tick(1);
        chk("man_src_low", {31'd0, sw_src}, 32'h0);
        chk("man_done", {31'd0, probe_done}, 32'h1);
        chk("man_cnt", {16'd0, probe_cnt}, 32'h1);
        tick(2);
        key_step = 1'b0;
        tick(12);
        chk("man_one_pulse", pulses, 1);

        // Glitch shorter than debounce
        key_step = 1'b1; tick(2); key_step = 1'b0;
        tick(15);
        chk("glitch_pulses", pulses, 1);
        chk("glitch_cnt", {16'd0, probe_cnt}, 32'h1);

        // Write hazard holds ARM
        sw_addr = 8'h40; key_step = 1'b1;
        wait_arm(20);
        mem_we = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (sw_src !== 1'b0) bad++;
        end
        chk("haz_src_low", bad, 0);
        mem_we = 1'b0;
        tick(1);
        chk("haz_src_high", {31'd0, sw_src}, 32'h1);
        chk("haz_io", {24'd0, io}, 32'h40);
        key_step = 1'b0;
        tick(12);
        chk("haz_cnt", {16'd0, probe_cnt}, 32'h2);

        // Auto-scan
        key_auto = 1'b1; tick(8); key_auto = 1'b0;
        chk("auto_on", {31'd0, auto_mode}, 32'h1);
        wait_src(40, n);
        chk("auto_io0", {24'd0, io}, 32'h00);
        key_step = 1'b1; tick(10); key_step = 1'b0;
        wait_src(40, n);
        chk("auto_io1", {24'd0, io}, 32'h04);
        chk("auto_period1", 10 + n, 20);
        tick(1);
        wait_src(40, n);
        chk("auto_io2", {24'd0, io}, 32'h08);
        chk("auto_period2", 1 + n, 20);
        bad = 0;
        for (int i = 3; i <= 64; i++) begin
            tick(1);
            wait_src(40, n);
            if (io !== 8'((i * 4) % 256)) bad++;
        end
        chk("auto_walk", bad, 0);
        chk("auto_wrap_io", {24'd0, io}, 32'h00);
        tick(2);
        chk("auto_cnt", {16'd0, probe_cnt}, 32'd67);
        key_auto = 1'b1; tick(8); key_auto = 1'b0;
        tick(10);
        chk("auto_off", {31'd0, auto_mode}, 32'h0);
        chk("auto_off_cnt", {16'd0, probe_cnt}, 32'd67);

        // Trigger during ARM is dropped
        base = pulses;
        sw_addr = 8'h55; key_step = 1'b1;
        wait_arm(20);
        mem_we = 1'b1; key_step = 1'b0;
        tick(10);
        key_step = 1'b1; tick(10); key_step = 1'b0;
        tick(10);
        mem_we = 1'b0;
        tick(20);
        chk("ovl_pulses", pulses - base, 1);
        chk("ovl_cnt", {16'd0, probe_cnt}, 32'd68);
        chk("ovl_io", {24'd0, last_io}, 32'h55);

        // Counter wrap
        force dut.probe_cnt = 16'hFFFF;
        tick(1);
        release dut.probe_cnt;
        sw_addr = 8'h0A; key_step = 1'b1;
        wait_src(20, n);
        tick(1);
        chk("wrap_done", {31'd0, probe_done}, 32'h1);
        chk("wrap_cnt", {16'd0, probe_cnt}, 32'h0000);
        key_step = 1'b0;
        tick(12);

        // Reset while in ARM
        base = pulses;
        sw_addr = 8'h77; key_step = 1'b1;
        wait_arm(20);
        mem_we = 1'b1;
        rst_n = 1'b1; key_step = 1'b0;
        tick(1);
        mem_we = 1'b0;
        chk("mrst_io", {24'd0, io}, 32'h0);
        chk("mrst_src", {31'd0, sw_src}, 32'h0);
        chk("mrst_state", {30'd0, dut.state}, {30'd0, IDLE});
        rst_n = 1'b0;
        tick(15);
        chk("mrst_pulses", pulses - base, 0);
        chk("mrst_cnt", {16'd0, probe_cnt}, 32'h0);

        chk("total_pulses", pulses, 69);
        chk("pulse_width", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_probe_ctrl.md
Name: mem_probe_ctrl

Overview:
- Front-end controller that feeds the data-memory IO probe path of the single-cycle core: drives the 8-bit `io` address and the `SW_Src` select.
- Debounces and synchronises board keys and produces one-cycle, write-safe probe pulses, so the core's `out_read` register captures exactly one word per request.
- Supports manual probing (switch address, step key) and auto-scan (address walks at a fixed rate).
- Sits between board I/O pins and the core top level.

Parameters:
- DEB_CYC, 500000, cycles a synchronised key must stay stable before its debounced level changes
- SCAN_DIV, 25000000, cycles between auto-scan probes
- ADDR_STEP, 4, auto-scan address increment (byte address, 8-bit wrap)
- CNT_W, 25, width of the debounce and scan counters; must hold max(DEB_CYC, SCAN_DIV)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous reset; ACTIVE-HIGH (1 = reset) despite the name, sampled on the clk rising edge
- sw_addr  in  8  raw switch address for manual mode, asynchronous
- key_step  in  1  raw step button (1 = pressed), asynchronous
- key_auto  in  1  raw auto-mode toggle button (1 = pressed), asynchronous
- mem_we  in  1  core MemWrite; a probe must not overlap a store
- io  out  8  probe byte address to the core
- sw_src  out  1  probe select to the core; high for exactly one cycle per probe
- auto_mode  out  1  current mode, 1 = auto-scan
- probe_done  out  1  one-cycle pulse the cycle after sw_src; out_read is valid from then on
- probe_cnt  out  16  probes completed, wraps at 0xFFFF→0

Behaviour:
- Reset (rst_n==1 at a clock edge):
  - FSM goes to IDLE.
  - io=0, sw_src=0, auto_mode=0, probe_done=0, probe_cnt=0.
  - Scan address=0; all counters=0.
  - Debounced key levels=0.
  - Reset mid-probe aborts with no sw_src pulse.
- Input sync: key_step, key_auto and sw_addr each pass through two flip-flops. sw_addr is only sampled when a manual probe is armed.
- Debounce (per key):
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments; on reaching DEB_CYC-1 the debounced level takes the synced level and the counter clears.
  - A rising edge of the debounced level gives a one-cycle event.
- auto_mode toggles on each key_auto event. On entry to auto mode: scan address and scan counter clear to 0.
- Triggers:
  - Manual mode: key_step event.
  - Auto mode: scan counter reaching SCAN_DIV-1; the counter then wraps to 0. key_step is ignored in auto mode.
  - A trigger arriving while the FSM is not IDLE is dropped, not queued.
- FSM states: IDLE, ARM, CAPTURE, DONE.
  - IDLE→ARM on trigger. io loads sw_addr (synced) in manual mode, or the scan address in auto mode.
  - ARM: io stable, sw_src=0. Leave for CAPTURE in the first cycle with mem_we==0; stay in ARM while mem_we==1 (no timeout).
  - CAPTURE: sw_src=1 for exactly this cycle. The core latches Mem_Result at the closing edge. mem_we is ignored here.
  - DONE:
    - probe_done=1 and probe_cnt increments.
    - In auto mode the scan address advances by ADDR_STEP, mod 256 (0xFC+4→0x00).
    - Go to IDLE the next cycle.
- Latency: trigger to sw_src high is 2 cycles minimum (IDLE→ARM→CAPTURE), plus one cycle per cycle of mem_we==1 in ARM.
- Output timing: io holds its value after DONE until the next trigger. All outputs are registered.
- Mode toggle mid-probe: the current probe completes using the io already loaded. The scan address does not advance if auto_mode is 0 in DONE.

Decomposition:
- Package mem_probe_pkg holds:
  - typedef enum logic [1:0] probe_state_t {IDLE, ARM, CAPTURE, DONE}
  - localparam IO_W=8
  - localparam PCNT_W=16
- Sub-module key_debounce (params DEB_CYC, CNT_W; ports clk, rst_n, raw, level, rise) is instantiated twice. It contains the 2-FF synchroniser.

Test Plan (DEB_CYC=4, SCAN_DIV=20):
- Reset: hold rst_n=1 for 3 cycles with keys pressed → all outputs 0; release → no probe for at least 20 cycles with keys released.
- Manual: sw_addr=0x1C, press key_step for 10 cycles → exactly one sw_src pulse with io=0x1C; probe_done the next cycle; probe_cnt=1. A 2-cycle glitch pulse on key_step → no probe.
- Write hazard: mem_we=1 for 5 cycles starting the cycle ARM is entered → sw_src stays 0 throughout; sw_src=1 in the first cycle after mem_we falls.
- Auto-scan: press key_auto → auto_mode=1; probes every 20 cycles with io=0x00,0x04,0x08; key_step presses ignored. Start with scan address forced to 0xFC → next io=0x00.
- Overlap and wrap: a trigger during ARM is dropped (probe_cnt rises by 1, not 2). Preload probe_cnt=0xFFFF, then one probe → 0x0000.
- Mid-probe reset: assert rst_n in ARM → sw_src never asserts; io=0; state IDLE.
